// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM update controller: FSM state encoding.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RAMP    = 2'd2
  } pwm_upd_state_t;

endpackage : pwm_pkg

// File: rtl/pwm_duty_slew.sv
// Combinational duty slew: moves cur toward target by at most step.
// A zero step means jump straight to target. The difference is computed
// before stepping, so the result never wraps and never overshoots.
module pwm_duty_slew
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic [CNT_WIDTH-1:0]  cur,
  input  logic [CNT_WIDTH-1:0]  target,
  input  logic [STEP_WIDTH-1:0] step,
  output logic [CNT_WIDTH-1:0]  next,
  output logic                  reached
);

  logic [CNT_WIDTH-1:0] step_ext_s;
  logic [CNT_WIDTH-1:0] diff_s;
  logic                 up_s;

  assign step_ext_s = CNT_WIDTH'(step);

  // Magnitude and direction of the remaining distance to target.
  always_comb begin
    up_s   = 1'b0;
    diff_s = '0;
    if (target >= cur) begin
      up_s   = 1'b1;
      diff_s = target - cur;
    end else begin
      up_s   = 1'b0;
      diff_s = cur - target;
    end
  end

  // Clamp the step to the remaining distance so the ramp lands exactly.
  always_comb begin
    next = cur;
    if ((step == {STEP_WIDTH{1'b0}}) || (diff_s <= step_ext_s)) begin
      next = target;
    end else if (up_s) begin
      next = cur + step_ext_s;
    end else begin
      next = cur - step_ext_s;
    end
  end

  assign reached = (next == target);

endmodule : pwm_duty_slew

// File: rtl/pwm_update_ctrl.sv
// PWM update controller: accepts a new period/duty/enable configuration,
// holds it in shadow registers and applies it only at period boundaries,
// optionally slewing the duty by a bounded step per period.
module pwm_update_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned STEP_WIDTH = 16,
  parameter int unsigned PERIOD_RST = 32'd1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [CNT_WIDTH-1:0]  cfg_duty,
  input  logic [STEP_WIDTH-1:0] cfg_step,
  input  logic                  cfg_enable,
  input  logic                  period_end,
  output logic [CNT_WIDTH-1:0]  period_cycles,
  output logic [CNT_WIDTH-1:0]  duty_cycles,
  output logic                  enable,
  output logic                  busy,
  output logic                  update_done
);

  pwm_upd_state_t        state_r;

  logic [CNT_WIDTH-1:0]  sh_period_r;
  logic [CNT_WIDTH-1:0]  sh_duty_r;
  logic [STEP_WIDTH-1:0] sh_step_r;
  logic                  sh_enable_r;

  logic [CNT_WIDTH-1:0]  period_r;
  logic [CNT_WIDTH-1:0]  duty_r;
  logic                  enable_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  accept_s;
  logic [CNT_WIDTH-1:0]  duty_next_s;
  logic                  duty_reached_s;

  // A new request can only be taken while nothing waits for a boundary.
  assign cfg_ready = (state_r != PENDING);
  assign accept_s  = cfg_valid && cfg_ready;

  assign period_cycles = period_r;
  assign duty_cycles   = duty_r;
  assign enable        = enable_r;
  assign busy          = busy_r;
  assign update_done   = done_r;

  // Next duty value one slew step from the live output toward the shadow target.
  pwm_duty_slew #(
    .CNT_WIDTH  (CNT_WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_duty_slew (
    .cur     (duty_r),
    .target  (sh_duty_r),
    .step    (sh_step_r),
    .next    (duty_next_s),
    .reached (duty_reached_s)
  );

  // Update FSM: captures shadows on accept, applies them at period_end only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sh_period_r <= '0;
      sh_duty_r   <= '0;
      sh_step_r   <= '0;
      sh_enable_r <= 1'b0;
      period_r    <= CNT_WIDTH'(PERIOD_RST);
      duty_r      <= '0;
      enable_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // period_end is ignored here, even when it coincides with accept.
          if (accept_s) begin
            sh_period_r <= cfg_period;
            sh_duty_r   <= cfg_duty;
            sh_step_r   <= cfg_step;
            sh_enable_r <= cfg_enable;
            state_r     <= PENDING;
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end

        PENDING: begin
          if (period_end) begin
            period_r <= sh_period_r;
            enable_r <= sh_enable_r;
            if (!sh_enable_r) begin
              // Disabling drops the duty at once; no ramp down.
              duty_r  <= '0;
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else if (duty_reached_s) begin
              duty_r  <= duty_next_s;
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              duty_r  <= duty_next_s;
              state_r <= RAMP;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= PENDING;
            busy_r  <= 1'b1;
          end
        end

        RAMP: begin
          if (accept_s) begin
            // A coincident boundary still takes one step toward the old target.
            if (period_end) begin
              duty_r <= duty_next_s;
            end else begin
              duty_r <= duty_r;
            end
            sh_period_r <= cfg_period;
            sh_duty_r   <= cfg_duty;
            sh_step_r   <= cfg_step;
            sh_enable_r <= cfg_enable;
            state_r     <= PENDING;
            busy_r      <= 1'b1;
          end else if (period_end) begin
            duty_r <= duty_next_s;
            if (duty_reached_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RAMP;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= RAMP;
            busy_r  <= 1'b1;
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule : pwm_update_ctrl

// File: tb/tb_pwm_update_ctrl.sv
// Directed self-checking bench for pwm_update_ctrl.
module tb_pwm_update_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_period;
  logic [31:0] cfg_duty;
  logic [15:0] cfg_step;
  logic        cfg_enable;
  logic        period_end;
  logic [31:0] period_cycles;
  logic [31:0] duty_cycles;
  logic        enable;
  logic        busy;
  logic        update_done;

  int errors = 0;
  int checks = 0;

  pwm_update_ctrl #(
    .CNT_WIDTH  (32),
    .STEP_WIDTH (16),
    .PERIOD_RST (32'd1000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .cfg_step      (cfg_step),
    .cfg_enable    (cfg_enable),
    .period_end    (period_end),
    .period_cycles (period_cycles),
    .duty_cycles   (duty_cycles),
    .enable        (enable),
    .busy          (busy),
    .update_done   (update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [31:0] per, input logic [31:0] dty,
                      input logic en, input logic bsy, input logic dn);
    chk({tag, ".period"}, period_cycles, per);
    chk({tag, ".duty"},   duty_cycles,   dty);
    chk({tag, ".enable"}, {31'd0, enable},      {31'd0, en});
    chk({tag, ".busy"},   {31'd0, busy},        {31'd0, bsy});
    chk({tag, ".done"},   {31'd0, update_done}, {31'd0, dn});
  endtask

  // Present one request for a single edge (accepted when cfg_ready is high).
  task automatic send(input logic [31:0] per, input logic [31:0] dty,
                      input logic [15:0] stp, input logic en, input logic pe);
    cfg_valid  = 1'b1;
    cfg_period = per;
    cfg_duty   = dty;
    cfg_step   = stp;
    cfg_enable = en;
    period_end = pe;
    tick();
    cfg_valid  = 1'b0;
    period_end = 1'b0;
  endtask

  task automatic pe_pulse();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_period = 32'd0;
    cfg_duty   = 32'd0;
    cfg_step   = 16'd0;
    cfg_enable = 1'b0;
    period_end = 1'b0;
    tick();
    tick();

    // Reset state
    outs("rst", 32'd1000, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Immediate apply, nothing changes before the boundary
    send(32'd500, 32'd250, 16'd0, 1'b1, 1'b0);
    outs("pend0", 32'd1000, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("pend.ready", {31'd0, cfg_ready}, 32'd0);
    tick();
    tick();
    outs("pend2", 32'd1000, 32'd0, 1'b0, 1'b1, 1'b0);
    pe_pulse();
    outs("apply", 32'd500, 32'd250, 1'b1, 1'b0, 1'b1);
    chk("apply.ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    outs("apply+1", 32'd500, 32'd250, 1'b1, 1'b0, 1'b0);

    // period_end in IDLE is ignored
    pe_pulse();
    outs("idle_pe", 32'd500, 32'd250, 1'b1, 1'b0, 1'b0);

    // Ramp 0 -> 100 by 40
    send(32'd500, 32'd0, 16'd0, 1'b1, 1'b0);
    pe_pulse();
    chk("zero.duty", duty_cycles, 32'd0);
    send(32'd500, 32'd100, 16'd40, 1'b1, 1'b0);
    pe_pulse();
    outs("ramp40", 32'd500, 32'd40, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ramp.hold", duty_cycles, 32'd40);
    pe_pulse();
    outs("ramp80", 32'd500, 32'd80, 1'b1, 1'b1, 1'b0);
    pe_pulse();
    outs("ramp100", 32'd500, 32'd100, 1'b1, 1'b0, 1'b1);

    // Retarget mid-ramp with coincident period_end: 30 -> 80 -> (130) -> 80 -> 30 -> 10
    send(32'd500, 32'd30, 16'd0, 1'b1, 1'b0);
    pe_pulse();
    chk("set30.duty", duty_cycles, 32'd30);
    send(32'd500, 32'd200, 16'd50, 1'b1, 1'b0);
    pe_pulse();
    outs("r80", 32'd500, 32'd80, 1'b1, 1'b1, 1'b0);
    send(32'd500, 32'd10, 16'd50, 1'b1, 1'b1);
    outs("r130", 32'd500, 32'd130, 1'b1, 1'b1, 1'b0);
    chk("r130.ready", {31'd0, cfg_ready}, 32'd0);
    pe_pulse();
    outs("d80", 32'd500, 32'd80, 1'b1, 1'b1, 1'b0);
    pe_pulse();
    outs("d30", 32'd500, 32'd30, 1'b1, 1'b1, 1'b0);
    pe_pulse();
    outs("d10", 32'd500, 32'd10, 1'b1, 1'b0, 1'b1);

    // Accept in IDLE coincident with period_end does not apply yet
    send(32'd600, 32'd300, 16'd0, 1'b1, 1'b1);
    outs("idle_acc_pe", 32'd500, 32'd10, 1'b1, 1'b1, 1'b0);
    pe_pulse();
    outs("set300", 32'd600, 32'd300, 1'b1, 1'b0, 1'b1);

    // Disable drops duty to zero immediately
    send(32'd600, 32'd300, 16'd10, 1'b0, 1'b0);
    outs("dis_pend", 32'd600, 32'd300, 1'b1, 1'b1, 1'b0);
    pe_pulse();
    outs("disabled", 32'd600, 32'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-ramp
    send(32'd700, 32'd100, 16'd0, 1'b1, 1'b0);
    pe_pulse();
    chk("pre.duty", duty_cycles, 32'd100);
    send(32'd700, 32'd500, 16'd100, 1'b1, 1'b0);
    pe_pulse();
    outs("mid", 32'd700, 32'd200, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    outs("async_rst", 32'd1000, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    rst = 1'b0;
    pe_pulse();
    outs("post_rst1", 32'd1000, 32'd0, 1'b0, 1'b0, 1'b0);
    pe_pulse();
    outs("post_rst2", 32'd1000, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pwm_update_ctrl

// File: doc/pwm_update_ctrl.md
PWM_UPDATE_CTRL -- requirements
Module: pwm_update_ctrl

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of period/duty/count values.
REQ-002 Parameter: STEP_WIDTH, default 16, width of duty slew step.
REQ-003 Parameter: PERIOD_RST, default 1000, period_cycles value after reset.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: cfg_valid  in  1  configuration request valid.
REQ-007 Port: cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
REQ-008 Port: cfg_period  in  CNT_WIDTH  requested period in clk cycles.
REQ-009 Port: cfg_duty  in  CNT_WIDTH  target duty in clk cycles.
REQ-010 Port: cfg_step  in  STEP_WIDTH  max duty change per period; 0 = immediate.
REQ-011 Port: cfg_enable  in  1  requested PWM enable.
REQ-012 Port: period_end  in  1  one-cycle pulse from timebase on last count of each period.
REQ-013 Port: period_cycles  out  CNT_WIDTH  period to timebase (registered).
REQ-014 Port: duty_cycles  out  CNT_WIDTH  duty to compare stage (registered).
REQ-015 Port: enable  out  1  enable to compare stage (registered).
REQ-016 Port: busy  out  1  high whenever state != IDLE.
REQ-017 Port: update_done  out  1  one-cycle pulse when target fully applied.

Function
REQ-018 States SHALL be IDLE, PENDING, RAMP; cfg_ready = (state != PENDING), combinational.
REQ-019 On accept, cfg_period/duty/step/enable SHALL be captured into shadow registers and state SHALL go to PENDING.
REQ-020 Outputs SHALL change only on a clk edge where period_end=1 in PENDING or RAMP; never mid-period.
REQ-021 PENDING && period_end: period_cycles <= shadow period, enable <= shadow enable, duty stepped per REQ-023; new values visible the cycle after period_end.
REQ-022 If shadow enable=0 on apply: duty_cycles <= 0, state -> IDLE, update_done pulses, ramp skipped.
REQ-023 Duty step: if step==0 or |target-duty| <= step then duty <= target, else duty <= duty +/- step toward target; step zero-extended to CNT_WIDTH; no overflow, no overshoot.
REQ-024 After a step, duty==target -> IDLE with update_done=1 for that cycle; else -> RAMP.
REQ-025 RAMP && period_end: one further step per REQ-023/REQ-024 toward shadow target.
REQ-026 Accept in RAMP: shadows overwritten, state -> PENDING; ramp resumes from current duty_cycles at next period_end.
REQ-027 Accept and period_end same cycle in RAMP: step uses old shadow target, new config captured, state -> PENDING, no update_done.
REQ-028 period_end in IDLE SHALL be ignored; accept in IDLE with period_end same cycle SHALL NOT apply until the following period_end.
REQ-029 Duty and period SHALL be passed unclamped; saturation is the downstream compare/timebase's job.

Reset
REQ-030 On rst: state IDLE, period_cycles=PERIOD_RST, duty_cycles=0, enable=0, update_done=0, busy=0, shadows cleared; cfg_ready=1 once state is IDLE.
REQ-031 rst mid-RAMP/PENDING SHALL discard pending config with no update_done.

Structure
REQ-032 Shared package pwm_pkg SHALL hold the state enum pwm_upd_state_t.
REQ-033 Duty slew arithmetic SHALL be a combinational sub-module pwm_duty_slew (cur, target, step -> next, reached).

Verification
REQ-034 Reset, PERIOD_RST=1000 -> period_cycles=1000, duty=0, enable=0, cfg_ready=1, busy=0.
REQ-035 Accept period=500,duty=250,step=0,enable=1; period_end 3 cycles later -> outputs 500/250/1 next cycle, update_done one pulse, no change before period_end.
REQ-036 From duty=0, accept duty=100,step=40 -> duty 40,80,100 on three successive period_ends; update_done only with 100.
REQ-037 In RAMP at duty=80 toward 200, accept duty=10,step=50 coincident with period_end -> duty=130, state PENDING, then 80,30,10.
REQ-038 Enabled at duty=300, accept enable=0,step=10 -> at period_end duty=0, enable=0, update_done, IDLE.
REQ-039 Assert rst while RAMP mid-way -> all outputs to reset values immediately, no update_done afterwards.
